// File: rtl/snake_pkg.sv
// Shared direction definitions for the snake game: encodings, one-hot mapping,
// opposite-direction test and press-priority pick.
package snake_pkg;

    localparam int unsigned NumKeys  = 5;
    localparam int unsigned KeyPause = 4;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_e;

    // One-hot {right, left, down, up} as seen by the picture generator.
    function automatic logic [3:0] dir_onehot(input dir_e d);
        logic [3:0] oh;
        oh = 4'b0000;
        unique case (d)
            DirUp:    oh = 4'b0001;
            DirDown:  oh = 4'b0010;
            DirLeft:  oh = 4'b0100;
            DirRight: oh = 4'b1000;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    function automatic dir_e dir_opposite(input dir_e d);
        return dir_e'({d[1], ~d[0]});
    endfunction

    // Priority up > down > left > right among simultaneous press events.
    function automatic dir_e dir_pick(input logic [3:0] ev);
        dir_e d;
        if (ev[0]) begin
            d = DirUp;
        end else if (ev[1]) begin
            d = DirDown;
        end else if (ev[2]) begin
            d = DirLeft;
        end else begin
            d = DirRight;
        end
        return d;
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_key.sv
// Per-key conditioning: 2-flop synchronizer, stable-time debounce and a
// one-cycle press pulse on a stable 1->0 transition (releases are silent).
module key_debounce #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic press_o
);

    localparam int unsigned CntW   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    // The counter never holds DB_CYCLES-1: the step that would reach it commits instead.
    localparam int unsigned Thresh = (DB_CYCLES > 1) ? DB_CYCLES - 2 : 0;
    localparam logic [CntW-1:0] CntThresh = CntW'(Thresh);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Synchronize the raw button; idle (released) level is 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreement with the stable value; commit when it lasts long enough.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntThresh) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and registered press pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: debounced buttons, reversal-safe direction
// commit on each step tick, and a RUN/PAUSED step timer.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 500000,
    parameter int unsigned STEP_CYCLES = 6250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key,
    output logic [3:0] key_out,
    output logic       move_tick,
    output logic       paused
);

    localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);

    typedef enum logic {
        StRun,
        StPaused
    } state_e;

    logic [NumKeys-1:0] press;
    logic [3:0]         dir_ev;
    logic               pause_ev;
    dir_e               dir_win;
    dir_e               ref_dir;

    state_e             state_q, state_d;
    logic [StepW-1:0]   step_q, step_d;
    dir_e               commit_q, commit_d;
    dir_e               pend_q, pend_d;
    logic               move_tick_q;
    logic               paused_q;
    logic [3:0]         key_out_q;

    for (genvar i = 0; i < NumKeys; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_key (
            .clk_i  (clk),
            .rst_i  (rst),
            .key_i  (key[i]),
            .press_o(press[i])
        );
    end

    assign dir_ev   = press[3:0];
    assign pause_ev = press[KeyPause];
    assign dir_win  = dir_pick(dir_ev);

    // Next state: step timer, commit on tick, reversal filter against the direction
    // the snake will actually be moving when the press takes effect.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        commit_d = commit_q;
        pend_d   = pend_q;
        ref_dir  = move_tick_q ? pend_q : commit_q;
        if (state_q == StRun) begin
            step_d = (step_q == StepLast) ? '0 : step_q + 1'b1;
            if (move_tick_q) begin
                commit_d = pend_q;
            end
            if ((|dir_ev) && (dir_win != dir_opposite(ref_dir))) begin
                pend_d = dir_win;
            end
        end
        if (pause_ev) begin
            state_d = (state_q == StRun) ? StPaused : StRun;
        end
    end

    // State and registered outputs; move_tick is high exactly while running at the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            step_q      <= '0;
            commit_q    <= DirRight;
            pend_q      <= DirRight;
            move_tick_q <= 1'b0;
            paused_q    <= 1'b0;
            key_out_q   <= 4'b1000;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            commit_q    <= commit_d;
            pend_q      <= pend_d;
            move_tick_q <= (state_d == StRun) && (step_d == StepLast);
            paused_q    <= (state_d == StPaused);
            key_out_q   <= dir_onehot(commit_d);
        end
    end

    assign key_out   = key_out_q;
    assign move_tick = move_tick_q;
    assign paused    = paused_q;

endmodule
